// File: rtl/generic_bus_ram_responder.sv
// ---------------------------------------------------------------------------
// generic_bus_ram_responder
//   Responder end of the generic bus. Word-organised RAM with programmable
//   access latency, byte-enabled writes and range/alignment error reporting.
//   Stands in for a real memory system behind a fetch or memory stage port.
//
// Parameters
//   BASE_ADDR    byte address of word 0
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   LATENCY      cycles from acceptance to completion (0..15)
//
// Ports
//   CLK      clock, rising edge
//   nRST     asynchronous active-low reset
//   addr     byte address, held by initiator until completion
//   wdata    write data
//   byte_en  write byte lanes, bit i -> wdata[8i+7:8i]
//   ren/wen  read / write request
//   rdata    read data, non-zero only in a read completion cycle
//   busy     request pending and not yet complete
//   error    error response, only in a completion cycle
//
// Build option
//   GENERIC_BUS_RESP_WRITE_PROTECT_EN : every write completes with error=1
//   and the array is never modified (ROM behaviour).
// ---------------------------------------------------------------------------

// One byte lane of the word array. Contents are not reset.
module generic_bus_ram_lane #(
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic [AW-1:0] idx,
   input  logic          we,
   input  logic [7:0]    wbyte,
   output logic [7:0]    rbyte
);
   logic [7:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) mem[idx] <= wbyte;
   end

   assign rbyte = mem[idx];
endmodule

module generic_bus_ram_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byte_en,
   input  logic        ren,
   input  logic        wen,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        error
);
   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   // One past the last byte; 33 bits so the top of the map cannot wrap.
   localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
`ifdef GENERIC_BUS_RESP_WRITE_PROTECT_EN
   localparam logic WR_PROT = 1'b1;
`else
   localparam logic WR_PROT = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        wen;
      logic        bad;
   } req_t;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   req_t       cap, cap_nx, live, act;
   logic       req, done;

   assign req = ren | wen;

   always_comb begin
      live       = '0;
      live.addr  = addr;
      live.wdata = wdata;
      live.be    = byte_en;
      live.wen   = wen;
      live.bad   = (addr[1:0] != 2'b00) | (addr < BASE_ADDR) |
                   ({1'b0, addr} >= END_ADDR) | (ren & wen);
   end

   // Zero latency completes on live inputs; otherwise on the captured request.
   assign act = (LATENCY == 0) ? live : cap;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cap_nx   = cap;
      busy     = 1'b0;
      done     = 1'b0;
      if (LATENCY == 0) begin
         done = req;
      end else begin
         case (state)
            IDLE: begin
               busy = req;
               if (req) begin
                  cap_nx   = live;
                  cnt_nx   = 4'(LATENCY - 1);
                  state_nx = WAIT;
               end
            end
            WAIT: begin
               if (!req) begin
                  // initiator withdrew (flush): drop silently
                  state_nx = IDLE;
               end else if (cnt != 4'd0) begin
                  busy   = 1'b1;
                  cnt_nx = cnt - 4'd1;
               end else begin
                  done     = 1'b1;
                  state_nx = IDLE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         cnt   <= '0;
         cap   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         cap   <= cap_nx;
      end
   end

   // Word index of the active request; out-of-range offsets are flagged bad
   // so whatever word they alias is never written or returned.
   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic          unused_off;
   assign off        = act.addr - BASE_ADDR;
   assign idx        = off[AW+1:2];
   assign unused_off = &{1'b0, off[31:AW+2], off[1:0]};

   logic [NUM_LANES-1:0][7:0] rd_lanes, wr_lanes;
   logic [NUM_LANES-1:0]      lane_we;
   logic                      wr_ok;

   // nRST gate keeps a reset asserted mid-access from committing anything.
   assign wr_ok    = done & act.wen & ~act.bad & ~WR_PROT & nRST;
   assign lane_we  = {NUM_LANES{wr_ok}} & act.be;
   assign wr_lanes = act.wdata;

   generic_bus_ram_lane #(.DEPTH(DEPTH_WORDS)) u_lane [NUM_LANES-1:0] (
      .CLK   (CLK),
      .idx   (idx),
      .we    (lane_we),
      .wbyte (wr_lanes),
      .rbyte (rd_lanes)
   );

   assign rdata = (done & ~act.wen & ~act.bad) ? rd_lanes : '0;
   assign error = done & (act.bad | (act.wen & WR_PROT));
endmodule
